// File: rtl/sdram_cmd_sequencer.sv
// sdram_cmd_sequencer
//  Waits for the SDRAM controller to finish power-up init, then issues a
//  fixed ROM list of 4-bit commands one at a time over a strobe/done
//  handshake. Once the list is finished it raises switch to hand the
//  controller over to user logic.
// Ports
//  clk        system clock, rising edge
//  rst        asynchronous active-low reset
//  init_comp  controller init complete (level)
//  cmd_done   controller finished the current command (1-cycle pulse)
//  cmd        command code: 0000 NOP, 0001 WRITE, 0010 READ, 0011 REFRESH
//  cmd_sent   00 idle, 01 issue strobe, 10 awaiting done, 11 list done
//  switch     list complete, controller released to user logic
module sdram_cmd_sequencer #(
  parameter int unsigned SEQ_LEN    = 4,
  parameter int unsigned GAP_CYCLES = 16,
  parameter int unsigned TIMEOUT    = 1024,
  parameter bit          LOOP       = 1'b0,
  // Nibble i holds the command for list index i.
  parameter logic [63:0] ROM        = 64'h0000_0000_0000_2321
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       init_comp,
  input  logic       cmd_done,
  output logic [3:0] cmd,
  output logic [1:0] cmd_sent,
  output logic       switch
);

  localparam int unsigned IDX_W   = $clog2(SEQ_LEN) + 1;
  localparam int unsigned CNT_MAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state, state_d;
  logic [IDX_W-1:0] index, index_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [3:0]       cmd_d;
  logic [1:0]       sent_d;
  logic             switch_d;
  logic [3:0]       rom_idx;

  // State, index, shared wait/gap counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      index    <= '0;
      cnt      <= '0;
      cmd      <= 4'b0000;
      cmd_sent <= 2'b00;
      switch   <= 1'b0;
    end else begin
      state    <= state_d;
      index    <= index_d;
      cnt      <= cnt_d;
      cmd      <= cmd_d;
      cmd_sent <= sent_d;
      switch   <= switch_d;
    end
  end

  // Next-state logic; outputs are decoded from the next state so the
  // registered outputs always describe the state being entered.
  always_comb begin
    state_d  = state;
    index_d  = index;
    cnt_d    = cnt;
    cmd_d    = 4'b0000;
    sent_d   = 2'b00;
    switch_d = 1'b0;
    rom_idx  = 4'(index_d);

    if (!init_comp) begin
      state_d = S_IDLE;
      index_d = '0;
      cnt_d   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          state_d = S_ISSUE;
          cnt_d   = '0;
        end
        S_ISSUE: begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
        S_WAIT: begin
          if (cmd_done) begin
            state_d = S_GAP;
            index_d = index + 1'b1;
            cnt_d   = '0;
          end else if (cnt == CNT_W'(TIMEOUT - 2)) begin
            // Counter would reach TIMEOUT-1: re-issue the same command.
            state_d = S_ISSUE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
            cnt_d = '0;
            if (index < IDX_W'(SEQ_LEN)) begin
              state_d = S_ISSUE;
            end else if (LOOP) begin
              index_d = '0;
              state_d = S_ISSUE;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: begin
          state_d = S_IDLE;
          index_d = '0;
          cnt_d   = '0;
        end
      endcase
    end

    rom_idx = 4'(index_d);
    case (state_d)
      S_ISSUE: begin
        cmd_d  = ROM[{rom_idx, 2'b00} +: 4];
        sent_d = 2'b01;
      end
      S_WAIT: begin
        cmd_d  = ROM[{rom_idx, 2'b00} +: 4];
        sent_d = 2'b10;
      end
      S_DONE: begin
        sent_d   = 2'b11;
        switch_d = 1'b1;
      end
      default: begin
        cmd_d  = 4'b0000;
        sent_d = 2'b00;
      end
    endcase
  end

endmodule

// File: tb/tb_sdram_cmd_sequencer.sv
// tb_sdram_cmd_sequencer
//  Self-checking bench for sdram_cmd_sequencer. Expected commands are pushed
//  to a queue when a scenario is set up and popped when the DUT strobes.
module tb_sdram_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       init_comp = 1'b0;
  logic       man_done = 1'b0;
  logic       auto_pulse = 1'b0;
  logic       cmd_done;
  logic [3:0] cmd;
  logic [1:0] cmd_sent;
  logic       switch;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_q[$];
  bit         auto_en = 1'b0;
  int         dly = 0;
  int         cyc_cnt = 0;

  assign cmd_done = man_done | auto_pulse;

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  sdram_cmd_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .init_comp (init_comp),
    .cmd_done  (cmd_done),
    .cmd       (cmd),
    .cmd_sent  (cmd_sent),
    .switch    (switch)
  );

  // Controller model: pulse cmd_done 3 cycles after each issue strobe.
  always @(negedge clk) begin
    auto_pulse = 1'b0;
    if (!auto_en) dly = 0;
    if (dly != 0) begin
      dly = dly - 1;
      if (dly == 0) auto_pulse = 1'b1;
    end
    if (auto_en && cmd_sent == 2'b01) dly = 3;
  end

  task automatic wait_strobe(input int budget, output bit got);
    int n;
    n = 0;
    got = 1'b0;
    while (!got && n < budget) begin
      @(negedge clk);
      n++;
      if (cmd_sent === 2'b01) got = 1'b1;
    end
  endtask

  task automatic pop_exp(output logic [3:0] e, output bit ok);
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      ok = 1'b1;
    end else begin
      e  = 4'bxxxx;
      ok = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; init_comp = 1'b0; man_done = 1'b0; auto_en = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (cmd !== 4'b0000) begin errors++; $display("FAIL reset_cmd: got %b want 0000", cmd); end
    checks++;
    if (cmd_sent !== 2'b00) begin errors++; $display("FAIL reset_sent: got %b want 00", cmd_sent); end
    checks++;
    if (switch !== 1'b0) begin errors++; $display("FAIL reset_switch: got %b want 0", switch); end
    rst = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if ({cmd, cmd_sent, switch} !== 7'd0) begin
      errors++; $display("FAIL idle_hold: got cmd=%b sent=%b sw=%b want 0/00/0", cmd, cmd_sent, switch);
    end
  endtask

  task automatic test_sequence;
    bit got, ok;
    logic [3:0] e;
    int prev;
    prev = 0;
    exp_q = {};
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0011); exp_q.push_back(4'b0010);
    auto_en = 1'b1;
    init_comp = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_strobe(60, got);
      pop_exp(e, ok);
      checks++;
      if (!got || !ok || cmd !== e) begin
        errors++; $display("FAIL seq_strobe%0d: seen=%0b cmd=%b want %b", i, got, cmd, e);
      end
      if (i > 0) begin
        checks++;
        if (cyc_cnt - prev < 17) begin
          errors++; $display("FAIL seq_spacing%0d: got %0d cycles want >=17", i, cyc_cnt - prev);
        end
      end
      prev = cyc_cnt;
      @(negedge clk);
      checks++;
      if (cmd_sent !== 2'b10 || cmd !== e) begin
        errors++; $display("FAIL seq_wait%0d: got sent=%b cmd=%b want 10/%b", i, cmd_sent, cmd, e);
      end
    end
    for (int n = 0; n < 60 && cmd_sent !== 2'b11; n++) @(negedge clk);
    checks++;
    if (cmd_sent !== 2'b11 || switch !== 1'b1 || cmd !== 4'b0000) begin
      errors++; $display("FAIL seq_done: got sent=%b sw=%b cmd=%b want 11/1/0000", cmd_sent, switch, cmd);
    end
    repeat (30) @(negedge clk);
    checks++;
    if (cmd_sent !== 2'b11 || switch !== 1'b1) begin
      errors++; $display("FAIL done_hold: got sent=%b sw=%b want 11/1", cmd_sent, switch);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL seq_queue: got %0d left want 0", exp_q.size());
    end
  endtask

  task automatic test_timeout;
    bit got, ok;
    logic [3:0] e;
    int n;
    auto_en = 1'b0;
    init_comp = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_sent !== 2'b00 || switch !== 1'b0) begin
      errors++; $display("FAIL done_release: got sent=%b sw=%b want 00/0", cmd_sent, switch);
    end
    exp_q.push_back(4'b0001);
    init_comp = 1'b1;
    wait_strobe(10, got);
    pop_exp(e, ok);
    checks++;
    if (!got || !ok || cmd !== e) begin
      errors++; $display("FAIL to_first: seen=%0b cmd=%b want %b", got, cmd, e);
    end
    n = 0;
    @(negedge clk);
    while (cmd_sent === 2'b10 && n < 1100) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 1023) begin errors++; $display("FAIL to_wait_len: got %0d want 1023", n); end
    checks++;
    if (cmd_sent !== 2'b01 || cmd !== 4'b0001) begin
      errors++; $display("FAIL to_reissue: got sent=%b cmd=%b want 01/0001", cmd_sent, cmd);
    end
    @(negedge clk);
    checks++;
    if (cmd_sent !== 2'b10) begin errors++; $display("FAIL to_rewait: got %b want 10", cmd_sent); end
    init_comp = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_init_drop;
    bit got, ok;
    logic [3:0] e;
    exp_q = {};
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010); exp_q.push_back(4'b0011);
    auto_en = 1'b1;
    init_comp = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_strobe(60, got);
      pop_exp(e, ok);
      checks++;
      if (!got || !ok || cmd !== e) begin
        errors++; $display("FAIL drop_strobe%0d: seen=%0b cmd=%b want %b", i, got, cmd, e);
      end
    end
    @(negedge clk);
    init_comp = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_sent !== 2'b00 || cmd !== 4'b0000) begin
      errors++; $display("FAIL drop_idle: got sent=%b cmd=%b want 00/0000", cmd_sent, cmd);
    end
    repeat (4) @(negedge clk);
    exp_q.push_back(4'b0001);
    init_comp = 1'b1;
    wait_strobe(10, got);
    pop_exp(e, ok);
    checks++;
    if (!got || !ok || cmd !== e) begin
      errors++; $display("FAIL drop_restart: seen=%0b cmd=%b want %b", got, cmd, e);
    end
    auto_en = 1'b0;
    init_comp = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_coincident_done;
    bit got, ok;
    logic [3:0] e;
    auto_en = 1'b0;
    exp_q = {};
    exp_q.push_back(4'b0001);
    init_comp = 1'b1;
    wait_strobe(10, got);
    pop_exp(e, ok);
    checks++;
    if (!got || !ok || cmd !== e) begin
      errors++; $display("FAIL coin_strobe: seen=%0b cmd=%b want %b", got, cmd, e);
    end
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    checks++;
    if (cmd_sent !== 2'b10 || cmd !== 4'b0001) begin
      errors++; $display("FAIL coin_ignored: got sent=%b cmd=%b want 10/0001", cmd_sent, cmd);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (cmd_sent !== 2'b10) begin errors++; $display("FAIL coin_stay: got %b want 10", cmd_sent); end
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    checks++;
    if (cmd_sent !== 2'b00 || cmd !== 4'b0000) begin
      errors++; $display("FAIL coin_accept: got sent=%b cmd=%b want 00/0000", cmd_sent, cmd);
    end
    exp_q.push_back(4'b0010);
    wait_strobe(40, got);
    pop_exp(e, ok);
    checks++;
    if (!got || !ok || cmd !== e) begin
      errors++; $display("FAIL coin_next: seen=%0b cmd=%b want %b", got, cmd, e);
    end
    init_comp = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_midrun;
    bit got, ok;
    logic [3:0] e;
    exp_q = {};
    auto_en = 1'b1;
    init_comp = 1'b1;
    exp_q.push_back(4'b0001);
    wait_strobe(10, got);
    pop_exp(e, ok);
    checks++;
    if (!got || !ok || cmd !== e) begin
      errors++; $display("FAIL rr_first: seen=%0b cmd=%b want %b", got, cmd, e);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({cmd, cmd_sent, switch} !== 7'd0) begin
      errors++; $display("FAIL rr_async1: got cmd=%b sent=%b sw=%b want 0/00/0", cmd, cmd_sent, switch);
    end
    repeat (5) @(negedge clk);
    rst = 1'b1;
    exp_q.push_back(4'b0001);
    wait_strobe(5, got);
    pop_exp(e, ok);
    checks++;
    if (!got || !ok || cmd !== e) begin
      errors++; $display("FAIL rr_release: seen=%0b cmd=%b want %b", got, cmd, e);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({cmd, cmd_sent, switch} !== 7'd0) begin
      errors++; $display("FAIL rr_async2: got cmd=%b sent=%b sw=%b want 0/00/0", cmd, cmd_sent, switch);
    end
    repeat (5) @(negedge clk);
    rst = 1'b1;
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0011); exp_q.push_back(4'b0010);
    for (int i = 0; i < 4; i++) begin
      wait_strobe(60, got);
      pop_exp(e, ok);
      checks++;
      if (!got || !ok || cmd !== e) begin
        errors++; $display("FAIL rr_replay%0d: seen=%0b cmd=%b want %b", i, got, cmd, e);
      end
    end
    for (int n = 0; n < 60 && cmd_sent !== 2'b11; n++) @(negedge clk);
    checks++;
    if (cmd_sent !== 2'b11 || switch !== 1'b1) begin
      errors++; $display("FAIL rr_done: got sent=%b sw=%b want 11/1", cmd_sent, switch);
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_timeout();
    test_init_drop();
    test_coincident_done();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
